imem_load_controller: RTL and testbench
=======================================

# imem_load_controller

Sequencer and port arbiter for the single-port instruction memory. It owns the memory's `write_en`/`instr_in`/`address` inputs. While loading, it assembles a host byte stream into 32-bit words and writes them to consecutive word addresses, holding the core in stall. Otherwise it passes the core's fetch address through for reads. It sits between the host loader link, the PC/fetch stage and the instruction memory.

## Interface
- `DEPTH`, 512, number of 32-bit words in the instruction memory
- `ADDR_W`, 9, word-index width (log2 DEPTH)
- `clk` in 1: single clock; all state updates on posedge
- `rst_n` in 1: asynchronous, active-low reset
- `load_start` in 1: begin a load; sampled in IDLE only
- `load_len` in ADDR_W+1: number of words to load; sampled with `load_start`
- `load_abort` in 1: cancel an in-progress load
- `byte_valid` in 1: host byte present
- `byte_data` in 8: host byte
- `byte_ready` out 1: controller accepts a byte this cycle
- `fetch_addr` in 32: word address from the fetch stage
- `mem_write_en` out 1: to memory `write_en`
- `mem_instr_in` out 32: to memory `instr_in`
- `mem_address` out 32: to memory `address`
- `core_stall` out 1: freezes PC/fetch
- `load_busy` out 1: load in progress
- `load_done` out 1: one-cycle pulse on successful completion
- `load_err` out 1: one-cycle pulse on rejected start or abort
- `word_count` out ADDR_W+1: words written in the current or last load

## Operation
- **States:**
  - IDLE: memory owned by fetch.
  - COLLECT: gather 4 bytes.
  - WRITE: one memory write.
  - FLUSH: one settle cycle.
- **IDLE:**
  - Outputs: `mem_address` = `fetch_addr` (combinational mux), `mem_write_en`=0, `byte_ready`=0.
  - `load_start` with 1 ≤ `load_len` ≤ DEPTH: latch len; clear `word_count` and the byte index; go to COLLECT.
  - `load_start` with `load_len`=0 or `load_len` > DEPTH: pulse `load_err`, stay in IDLE, `loaded` flag unchanged.
- **COLLECT:**
  - `byte_ready`=1. A byte is accepted when `byte_valid & byte_ready`.
  - Little-endian packing: byte 0 → [7:0], byte 1 → [15:8], byte 2 → [23:16], byte 3 → [31:24], into the `mem_instr_in` register.
  - Byte index is 2 bits. The 4th accepted byte moves the state to WRITE.
- **WRITE:**
  - `mem_write_en`=1, `mem_address` = zero-extended `word_count`, `byte_ready`=0.
  - Then increment `word_count`.
  - If the new count equals the latched len, go to FLUSH; else go to COLLECT.
- **FLUSH:**
  - `mem_write_en`=0, `mem_address` = `fetch_addr`.
  - Set `loaded`=1, pulse `load_done` on exit, go to IDLE.
  - Purpose: the memory read is registered, so this cycle lets the first fetch after load see written data.
- **Abort:**
  - `load_abort` in COLLECT or WRITE: go to IDLE next cycle, clear `loaded`, pulse `load_err`, discard the partial byte.
  - A WRITE cycle coinciding with abort still performs its write; `word_count` still increments.
  - Abort in IDLE or FLUSH is ignored.
- **Stall and busy:** `core_stall` = ~`loaded` | `load_busy`. `load_busy` = 1 in COLLECT, WRITE and FLUSH.
- **Start while busy:** `load_start` outside IDLE is ignored.

## Timing
- **Reset values:**
  - state IDLE; `loaded`=0.
  - `core_stall`=1; `load_busy`, `load_done`, `load_err`=0.
  - `byte_ready`=0, `mem_write_en`=0, `mem_instr_in`=0, `word_count`=0, byte index 0.
- **Reset mid-load:** returns to the reset values immediately. No further writes; memory contents already written stay as they are.
- **Latency:**
  - `load_start` → `byte_ready`=1 on the next cycle.
  - 4th byte accepted at cycle t → `mem_write_en`=1 in cycle t+1 → `byte_ready`=1 again at t+2.
  - Minimum 5 cycles per word.
- **Completion:** last write in cycle w → FLUSH at w+1 → IDLE at w+2, with `load_done`=1 and `core_stall`=0 at w+2 (provided `loaded`).
- **Handshake:** a byte is accepted only on `byte_valid & byte_ready`. If `byte_valid` stays high during WRITE, the byte is held, not lost. Gaps in `byte_valid` stall COLLECT indefinitely.
- **Width and wrap:** `word_count` never exceeds DEPTH, because len is checked ≤ DEPTH. The final address is DEPTH-1 and never wraps.
- **Single-cycle pulses:** `load_done` and `load_err` never assert together.

## Test plan
- **Reset:** hold `rst_n`=0, then release → `core_stall`=1, `load_busy`=0, `mem_write_en`=0, `mem_address`=`fetch_addr`.
- **Two-word load:** `load_len`=2, bytes 13,00,00,00,93,00,10,00 streamed back-to-back →
  - writes 0x00000013 at address 0 and 0x00100093 at address 1;
  - exactly 2 `mem_write_en` pulses;
  - `load_done` one cycle;
  - `core_stall`=0 from then on.
- **Gapped stream:** random `byte_valid` gaps, 3-word load → same words written; `byte_ready` low in every WRITE cycle; no byte dropped.
- **Rejected starts:** `load_len`=0, then `load_len`=513 → `load_err` pulse each time; no writes; state stays IDLE.
- **Abort:** abort after 6 bytes of a 4-word load →
  - 1 write (address 0);
  - `load_err` pulse;
  - `loaded`=0 and `core_stall`=1;
  - the new `load_start` afterwards is accepted.
- **Full depth and async reset:** full 512-word load → last write at address 511, `word_count`=512. Async `rst_n` assertion mid-WRITE → outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/imem_load_controller_if.sv
`default_nettype none
// =====================================================================
// imem_load_controller_if : host link, fetch address and IMEM port bundle
// Rev 1.0
// =====================================================================
interface imem_load_controller_if #(
    parameter int ADDR_W = 9
);
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              load_abort;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic [31:0]       fetch_addr;
    logic              mem_write_en;
    logic [31:0]       mem_instr_in;
    logic [31:0]       mem_address;
    logic              core_stall;
    logic              load_busy;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;

    // master: host loader plus fetch stage; slave: the load controller
    modport master (
        output load_start, load_len, load_abort, byte_valid, byte_data, fetch_addr,
        input  byte_ready, mem_write_en, mem_instr_in, mem_address,
               core_stall, load_busy, load_done, load_err, word_count
    );

    modport slave (
        input  load_start, load_len, load_abort, byte_valid, byte_data, fetch_addr,
        output byte_ready, mem_write_en, mem_instr_in, mem_address,
               core_stall, load_busy, load_done, load_err, word_count
    );
endinterface
`default_nettype wire

// File: rtl/imem_load_controller.sv
`default_nettype none
// =====================================================================
// imem_load_controller : packs host bytes into IMEM words, muxes fetch/load
// Rev 1.0
// =====================================================================
module imem_load_controller #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_load_controller_if.slave bus
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [ADDR_W:0] r_len;
    logic [ADDR_W:0] r_word_count;
    logic [ADDR_W:0] w_count_inc;
    logic [1:0]      r_byte_idx;
    logic [31:0]     r_instr;
    logic            r_loaded;
    logic            r_load_done;
    logic            r_load_err;

    logic            w_len_ok;
    logic            w_start;
    logic            w_reject;
    logic            w_abort;
    logic            w_accept;
    logic            w_byte_ready;
    logic            w_write_en;
    logic            w_busy;
    logic [31:0]     w_mem_addr;

    assign w_len_ok    = (bus.load_len != '0) && (bus.load_len <= c_depth);
    assign w_count_inc = r_word_count + c_one;
    assign w_busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_reject     = 1'b0;
        w_abort      = 1'b0;
        w_accept     = 1'b0;
        w_byte_ready = 1'b0;
        w_write_en   = 1'b0;
        w_mem_addr   = bus.fetch_addr;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.load_start) begin
                    if (w_len_ok) begin
                        w_start      = 1'b1;
                        w_next_state = ST_COLLECT;
                    end else begin
                        w_reject     = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                w_byte_ready = 1'b1;
                if (bus.load_abort) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (bus.byte_valid) begin
                    w_accept = 1'b1;
                    if (r_byte_idx == 2'd3) begin
                        w_next_state = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // The write itself is never cancelled; abort only redirects the next state.
                w_write_en = 1'b1;
                w_mem_addr = 32'(r_word_count);
                if (bus.load_abort) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_count_inc == r_len) begin
                    w_next_state = ST_FLUSH;
                end else begin
                    w_next_state = ST_COLLECT;
                end
            end
            ST_FLUSH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len        <= '0;
            r_word_count <= '0;
            r_byte_idx   <= 2'd0;
            r_instr      <= 32'd0;
            r_loaded     <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_load_done <= (r_state == ST_FLUSH);
            r_load_err  <= w_reject | w_abort;

            if (w_start) begin
                r_len        <= bus.load_len;
                r_word_count <= '0;
                r_byte_idx   <= 2'd0;
            end

            if (w_accept) begin
                r_instr[{r_byte_idx, 3'b000} +: 8] <= bus.byte_data;
                r_byte_idx                         <= r_byte_idx + 2'd1;
            end

            if (r_state == ST_WRITE) begin
                r_word_count <= w_count_inc;
            end

            if (r_state == ST_FLUSH) begin
                r_loaded <= 1'b1;
            end

            // Partially assembled bytes are dropped so the next load restarts at byte 0.
            if (w_abort) begin
                r_loaded   <= 1'b0;
                r_byte_idx <= 2'd0;
            end
        end
    end

    assign bus.byte_ready   = w_byte_ready;
    assign bus.mem_write_en = w_write_en;
    assign bus.mem_instr_in = r_instr;
    assign bus.mem_address  = w_mem_addr;
    assign bus.core_stall   = ~r_loaded | w_busy;
    assign bus.load_busy    = w_busy;
    assign bus.load_done    = r_load_done;
    assign bus.load_err     = r_load_err;
    assign bus.word_count   = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_controller.sv
`default_nettype none
// =====================================================================
// tb_imem_load_controller : directed/random bench with memory-level model
// Rev 1.0
// =====================================================================
module tb_imem_load_controller;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    imem_load_controller_if #(.ADDR_W(ADDR_W)) bus ();

    imem_load_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural view of the instruction memory and of the pulse outputs
    logic [31:0] tb_mem [DEPTH];
    int          wr_addrs [$];
    logic [31:0] exp_words [$];
    int          wr_cnt    = 0;
    int          rdy_viol  = 0;
    int          done_cnt  = 0;
    int          err_cnt   = 0;
    int          both_viol = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_write_en) begin
                wr_cnt++;
                wr_addrs.push_back(int'(bus.mem_address));
                if (bus.mem_address < DEPTH) tb_mem[bus.mem_address[ADDR_W-1:0]] = bus.mem_instr_in;
                if (bus.byte_ready) rdy_viol++;
            end
            if (bus.load_done) done_cnt++;
            if (bus.load_err) err_cnt++;
            if (bus.load_done && bus.load_err) both_viol++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        wr_cnt = 0; rdy_viol = 0; done_cnt = 0; err_cnt = 0;
        wr_addrs.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int   gap;
        logic acc;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) tick();
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = bus.byte_ready;
            tick();
        end
        if (!acc) chk("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_bytes(input int nbytes, input int max_gap);
        logic [31:0] w;
        for (int i = 0; i < nbytes; i++) begin
            w = exp_words[i / 4];
            send_byte(8'((w >> (8 * (i % 4))) & 32'hFF), max_gap);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic start(input int len);
        bus.load_len   = (ADDR_W+1)'(len);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic do_load(input int n, input int max_gap);
        int mism;
        clear_stats();
        bus.fetch_addr = $urandom();
        start(n);
        chk("ready_after_start", bus.byte_ready, 1);
        send_bytes(4 * n, max_gap);
        chk("last_write_en", bus.mem_write_en, 1);
        chk("last_write_addr", bus.mem_address, n - 1);
        tick();
        chk("flush_busy", bus.load_busy, 1);
        chk("flush_no_write", bus.mem_write_en, 0);
        chk("flush_addr_mux", bus.mem_address, bus.fetch_addr);
        chk("flush_done_low", bus.load_done, 0);
        tick();
        chk("done_pulse", bus.load_done, 1);
        chk("done_stall", bus.core_stall, 0);
        chk("done_busy", bus.load_busy, 0);
        tick();
        chk("done_one_cycle", bus.load_done, 0);
        chk("write_count", wr_cnt, n);
        chk("done_count", done_cnt, 1);
        chk("word_count", bus.word_count, n);
        chk("ready_in_write", rdy_viol, 0);
        mism = 0;
        for (int i = 0; i < n; i++) begin
            if (tb_mem[i] !== exp_words[i]) mism++;
            if (wr_addrs.size() > i && wr_addrs[i] != i) mism++;
        end
        chk("mem_contents", mism, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load_start = 1'b0;
        bus.load_len   = '0;
        bus.load_abort = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        bus.fetch_addr = 32'h0000_1234;

        // Reset state
        repeat (3) tick();
        chk("rst_stall", bus.core_stall, 1);
        chk("rst_busy", bus.load_busy, 0);
        chk("rst_wen", bus.mem_write_en, 0);
        chk("rst_addr", bus.mem_address, 32'h0000_1234);
        chk("rst_instr", bus.mem_instr_in, 0);
        chk("rst_ready", bus.byte_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_stall", bus.core_stall, 1);
        chk("post_rst_count", bus.word_count, 0);
        chk("post_rst_pulses", {bus.load_done, bus.load_err}, 0);

        // Two-word program from the literal byte stream
        exp_words = '{32'h0000_0013, 32'h0010_0093};
        do_load(2, 0);
        chk("mem0_literal", tb_mem[0], 32'h0000_0013);
        chk("mem1_literal", tb_mem[1], 32'h0010_0093);
        bus.fetch_addr = $urandom();
        tick();
        chk("idle_addr_mux", bus.mem_address, bus.fetch_addr);
        chk("idle_stall_stays_low", bus.core_stall, 0);

        // Rejected starts keep the loaded image
        clear_stats();
        start(0);
        chk("rej0_err", bus.load_err, 1);
        chk("rej0_busy", bus.load_busy, 0);
        chk("rej0_stall", bus.core_stall, 0);
        tick();
        chk("rej0_err_clear", bus.load_err, 0);
        start(DEPTH + 1);
        chk("rej513_err", bus.load_err, 1);
        chk("rej513_busy", bus.load_busy, 0);
        tick();
        chk("rej_writes", wr_cnt, 0);
        chk("rej_err_count", err_cnt, 2);

        // Abort while idle is ignored
        bus.load_abort = 1'b1;
        tick();
        bus.load_abort = 1'b0;
        chk("idle_abort_err", bus.load_err, 0);
        chk("idle_abort_stall", bus.core_stall, 0);

        // Gapped 3-word stream
        exp_words.delete();
        for (int i = 0; i < 3; i++) exp_words.push_back($urandom());
        do_load(3, 3);

        // Abort in COLLECT after 6 bytes of a 4-word load
        exp_words.delete();
        for (int i = 0; i < 4; i++) exp_words.push_back($urandom());
        clear_stats();
        start(4);
        send_bytes(6, 1);
        bus.load_abort = 1'b1;
        tick();
        bus.load_abort = 1'b0;
        chk("abort_err", bus.load_err, 1);
        chk("abort_busy", bus.load_busy, 0);
        chk("abort_stall", bus.core_stall, 1);
        chk("abort_writes", wr_cnt, 1);
        chk("abort_addr0", (wr_addrs.size() > 0) ? wr_addrs[0] : -1, 0);
        chk("abort_word0", tb_mem[0], exp_words[0]);
        chk("abort_count", bus.word_count, 1);
        tick();
        chk("abort_err_once", bus.load_err, 0);
        exp_words.delete();
        exp_words.push_back($urandom());
        do_load(1, 0);

        // Abort coinciding with WRITE still writes
        exp_words.delete();
        for (int i = 0; i < 2; i++) exp_words.push_back($urandom());
        clear_stats();
        start(2);
        send_bytes(4, 0);
        chk("wabort_wen", bus.mem_write_en, 1);
        bus.load_abort = 1'b1;
        tick();
        bus.load_abort = 1'b0;
        chk("wabort_err", bus.load_err, 1);
        chk("wabort_busy", bus.load_busy, 0);
        chk("wabort_writes", wr_cnt, 1);
        chk("wabort_count", bus.word_count, 1);
        chk("wabort_stall", bus.core_stall, 1);
        chk("wabort_word", tb_mem[0], exp_words[0]);

        // Full-depth load
        exp_words.delete();
        for (int i = 0; i < DEPTH; i++) exp_words.push_back($urandom());
        do_load(DEPTH, 0);
        chk("full_last_addr", (wr_addrs.size() > 0) ? wr_addrs[$] : -1, DEPTH - 1);

        // Asynchronous reset in the middle of a WRITE cycle
        exp_words.delete();
        for (int i = 0; i < 2; i++) exp_words.push_back($urandom());
        clear_stats();
        start(2);
        send_bytes(4, 0);
        chk("arst_pre_wen", bus.mem_write_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wen", bus.mem_write_en, 0);
        chk("arst_busy", bus.load_busy, 0);
        chk("arst_stall", bus.core_stall, 1);
        chk("arst_count", bus.word_count, 0);
        chk("arst_ready", bus.byte_ready, 0);
        chk("arst_instr", bus.mem_instr_in, 0);
        chk("arst_addr", bus.mem_address, bus.fetch_addr);
        #10 rst_n = 1'b1;
        repeat (3) tick();
        chk("arst_no_writes", wr_cnt, 0);
        chk("arst_idle", bus.load_busy, 0);
        chk("pulse_overlap", both_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
